// File: rtl/serial_vec_packer_if.sv
// Serial nibble stream in, packed 32x4-bit I/W launch bus out, MAC completion back.
// master = upstream source plus MAC side; slave = the packer.
interface serial_vec_packer_if;
    logic         s_valid;
    logic         s_is_w;
    logic [3:0]   s_data;
    logic         s_ready;
    logic         in_valid;
    logic         weight_valid;
    logic [127:0] I;
    logic [127:0] W;
    logic         out_valid;

    modport master (
        output s_valid, s_is_w, s_data, out_valid,
        input  s_ready, in_valid, weight_valid, I, W
    );

    modport slave (
        input  s_valid, s_is_w, s_data, out_valid,
        output s_ready, in_valid, weight_valid, I, W
    );
endinterface

// File: rtl/serial_vec_packer.sv
// Packs 32 input + 32 weight nibbles into 128-bit buses and fires a 1-cycle MAC launch,
// launch 1 cycle after the last nibble; s_ready drops for a full bank and outside LOAD.
module serial_vec_packer #(
    parameter int TIMEOUT = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_vec_packer_if.slave bus,
    output logic               err
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_WAIT} state_t;

    state_t         state_q, state_d;
    logic [5:0]     i_cnt_q, i_cnt_d;
    logic [5:0]     w_cnt_q, w_cnt_d;
    logic           w_new_q, w_new_d;
    logic [127:0]   i_bank_q, i_bank_d;
    logic [127:0]   w_bank_q, w_bank_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           err_q, err_d;

    logic           i_full, w_full, w_lock, s_rdy, fire;
    logic [4:0]     w_idx;

    assign i_full = (i_cnt_q == 6'd32);
    assign w_full = (w_cnt_q == 6'd32);
    // A full bank only refuses weights while it belongs to the current frame;
    // a bank retained from an earlier frame is replaced by the next weight nibble.
    assign w_lock = w_full && w_new_q;
    assign fire   = (state_q == ST_FIRE);

    always_comb begin
        state_d  = state_q;
        i_cnt_d  = i_cnt_q;
        w_cnt_d  = w_cnt_q;
        w_new_d  = w_new_q;
        i_bank_d = i_bank_q;
        w_bank_d = w_bank_q;
        timer_d  = timer_q;
        err_d    = err_q;
        s_rdy    = 1'b0;
        w_idx    = w_cnt_q[4:0];
        case (state_q)
            ST_LOAD: begin
                s_rdy = bus.s_is_w ? !w_lock : !i_full;
                if (bus.s_valid && s_rdy) begin
                    if (bus.s_is_w) begin
                        w_idx = w_full ? 5'd0 : w_cnt_q[4:0];
                        w_bank_d[{~w_idx, 2'b00} +: 4] = bus.s_data;
                        w_cnt_d = {1'b0, w_idx} + 6'd1;
                        w_new_d = 1'b1;
                    end else begin
                        i_bank_d[{~i_cnt_q[4:0], 2'b00} +: 4] = bus.s_data;
                        i_cnt_d = i_cnt_q + 6'd1;
                    end
                end
                if (i_cnt_d == 6'd32 && w_cnt_d == 6'd32) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
                i_cnt_d = 6'd0;
                w_new_d = 1'b0;
                timer_d = '0;
            end
            ST_WAIT: begin
                // Completion takes priority over an expiry on the same edge.
                if (bus.out_valid) begin
                    state_d = ST_LOAD;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_LOAD;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            i_cnt_q  <= 6'd0;
            w_cnt_q  <= 6'd0;
            w_new_q  <= 1'b0;
            i_bank_q <= '0;
            w_bank_q <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_cnt_q  <= i_cnt_d;
            w_cnt_q  <= w_cnt_d;
            w_new_q  <= w_new_d;
            i_bank_q <= i_bank_d;
            w_bank_q <= w_bank_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    assign bus.s_ready      = s_rdy;
    assign bus.in_valid     = fire;
    assign bus.weight_valid = fire && w_new_q;
    assign bus.I            = fire ? i_bank_q : '0;
    assign bus.W            = fire ? w_bank_q : '0;
    assign err              = err_q;
endmodule
